// File: rtl/rect_tool_ctrl_if.sv
// rtl/rect_tool_ctrl_if.sv - cursor/control inputs and rectangle corner outputs of the rectangle tool
interface rect_tool_ctrl_if;
  logic       rect_mode;
  logic       btn_mark;
  logic       cancel;
  logic       frame_start;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic [9:0] recg_x_pt1;
  logic [9:0] recg_y_pt1;
  logic [9:0] recg_x_pt2;
  logic [9:0] recg_y_pt2;
  logic [1:0] state_rect;
  logic       busy;
  logic       commit_done;

  modport master (
    output rect_mode, btn_mark, cancel, frame_start, cursor_x, cursor_y,
    input  recg_x_pt1, recg_y_pt1, recg_x_pt2, recg_y_pt2, state_rect, busy, commit_done
  );

  modport slave (
    input  rect_mode, btn_mark, cancel, frame_start, cursor_x, cursor_y,
    output recg_x_pt1, recg_y_pt1, recg_x_pt2, recg_y_pt2, state_rect, busy, commit_done
  );
endinterface

// File: rtl/rect_tool_ctrl.sv
// rtl/rect_tool_ctrl.sv - rectangle-fill tool sequencer: corner capture, preview, frame-aligned commit window
module rect_tool_ctrl #(
  parameter int         H_ACTIVE       = 640,
  parameter int         V_ACTIVE       = 480,
  parameter logic [9:0] PARK           = 10'h3FF,
  parameter int         COMMIT_FRAMES  = 1,
  parameter int         TIMEOUT_FRAMES = 255
) (
  input logic             clk,
  input logic             reset,
  rect_tool_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b10,
    S_ARM    = 2'b11,
    S_COMMIT = 2'b01
  } state_t;

  localparam logic [9:0] X_MAX     = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_MAX     = 10'(V_ACTIVE - 1);
  localparam logic [7:0] COMMIT_N  = 8'(COMMIT_FRAMES);
  localparam logic [7:0] TIMEOUT_N = 8'(TIMEOUT_FRAMES);

  state_t     state;
  logic [9:0] x1, y1, x2, y2;
  logic [9:0] p1x, p1y, p2x, p2y;
  logic [7:0] cnt;
  logic       busy_q, done_q;

  logic [9:0] cx, cy;
  logic       abort;
  logic [7:0] cnt_inc;

  assign cx      = (bus.cursor_x > X_MAX) ? X_MAX : bus.cursor_x;
  assign cy      = (bus.cursor_y > Y_MAX) ? Y_MAX : bus.cursor_y;
  assign abort   = bus.cancel | ~bus.rect_mode;
  assign cnt_inc = cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      x1     <= PARK;
      y1     <= PARK;
      x2     <= PARK;
      y2     <= PARK;
      p1x    <= PARK;
      p1y    <= PARK;
      p2x    <= PARK;
      p2y    <= PARK;
      cnt    <= 8'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          busy_q <= 1'b0;
          x1     <= PARK;
          y1     <= PARK;
          x2     <= PARK;
          y2     <= PARK;
          if (bus.btn_mark && bus.rect_mode) begin
            state  <= S_WAIT;
            busy_q <= 1'b1;
            p1x    <= cx;
            p1y    <= cy;
            x1     <= cx;
            y1     <= cy;
            x2     <= cx;
            y2     <= cy;
            cnt    <= 8'd0;
          end
        end
        S_WAIT: begin
          if (abort ||
              (!bus.btn_mark && bus.frame_start && TIMEOUT_N != 8'd0 && cnt_inc == TIMEOUT_N)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            x1     <= PARK;
            y1     <= PARK;
            x2     <= PARK;
            y2     <= PARK;
          end else if (bus.btn_mark) begin
            // Park while armed so the write-enable block sees nothing until the frame boundary.
            state <= S_ARM;
            p2x   <= cx;
            p2y   <= cy;
            x1    <= PARK;
            y1    <= PARK;
            x2    <= PARK;
            y2    <= PARK;
          end else begin
            x2 <= cx;
            y2 <= cy;
            if (bus.frame_start && TIMEOUT_N != 8'd0) cnt <= cnt_inc;
          end
        end
        S_ARM: begin
          if (abort) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (bus.frame_start) begin
            state <= S_COMMIT;
            x1    <= p1x;
            y1    <= p1y;
            x2    <= p2x;
            y2    <= p2y;
            cnt   <= 8'd0;
          end
        end
        S_COMMIT: begin
          // Atomic: only frame_start matters here; busy stays high through the done pulse.
          if (bus.frame_start) begin
            cnt <= cnt_inc;
            if (cnt_inc == COMMIT_N) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
              x1     <= PARK;
              y1     <= PARK;
              x2     <= PARK;
              y2     <= PARK;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.recg_x_pt1  = x1;
  assign bus.recg_y_pt1  = y1;
  assign bus.recg_x_pt2  = x2;
  assign bus.recg_y_pt2  = y2;
  assign bus.state_rect  = state;
  assign bus.busy        = busy_q;
  assign bus.commit_done = done_q;

endmodule

// File: tb/tb_rect_tool_ctrl.sv
// tb/tb_rect_tool_ctrl.sv - bench for rect_tool_ctrl: three parameter sets against a phase-level model
module tb_rect_tool_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rect_mode, btn_mark, cancel, frame_start;
  logic [9:0] cur_x, cur_y;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: COMMIT_FRAMES=2, TIMEOUT_FRAMES=3; 2: TIMEOUT_FRAMES=0.
  rect_tool_ctrl_if ifs[3] ();
  logic [43:0] act[3];

  for (genvar i = 0; i < 3; i++) begin : g_dut
    assign ifs[i].rect_mode   = rect_mode;
    assign ifs[i].btn_mark    = btn_mark;
    assign ifs[i].cancel      = cancel;
    assign ifs[i].frame_start = frame_start;
    assign ifs[i].cursor_x    = cur_x;
    assign ifs[i].cursor_y    = cur_y;
    assign act[i] = {ifs[i].state_rect, ifs[i].busy, ifs[i].commit_done,
                     ifs[i].recg_x_pt1, ifs[i].recg_y_pt1, ifs[i].recg_x_pt2, ifs[i].recg_y_pt2};
    rect_tool_ctrl #(
      .COMMIT_FRAMES  ((i == 1) ? 2 : 1),
      .TIMEOUT_FRAMES ((i == 0) ? 255 : (i == 1) ? 3 : 0)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifs[i].slave)
    );
  end

  // Phase 0 idle, 1 awaiting second corner, 2 armed, 3 committing.
  typedef struct {
    int ph;
    int p1x, p1y, p2x, p2y, lx, ly, frames;
    bit done;
  } mdl_t;

  mdl_t mdl[3];
  int   cf_of[3] = '{1, 2, 1};
  int   tf_of[3] = '{255, 3, 0};

  function automatic mdl_t step(mdl_t m, int cf, int tf, bit rst, bit mode, bit mark,
                                bit cncl, bit fs, int x, int y);
    int cx, cy;
    cx = (x > 639) ? 639 : x;
    cy = (y > 479) ? 479 : y;
    m.done = 0;
    if (rst) begin
      m.ph = 0; m.frames = 0;
      m.p1x = 'h3FF; m.p1y = 'h3FF; m.p2x = 'h3FF; m.p2y = 'h3FF;
      return m;
    end
    case (m.ph)
      0: if (mark && mode) begin
        m.ph = 1; m.p1x = cx; m.p1y = cy; m.lx = cx; m.ly = cy; m.frames = 0;
      end
      1: if (cncl || !mode) m.ph = 0;
         else if (mark) begin m.ph = 2; m.p2x = cx; m.p2y = cy; end
         else begin
           m.lx = cx; m.ly = cy;
           if (fs && tf != 0) begin
             m.frames++;
             if (m.frames == tf) m.ph = 0;
           end
         end
      2: if (cncl || !mode) m.ph = 0;
         else if (fs) begin m.ph = 3; m.frames = 0; end
      default: if (fs) begin
        m.frames++;
        if (m.frames == cf) begin m.ph = 0; m.done = 1; end
      end
    endcase
    return m;
  endfunction

  function automatic logic [43:0] expect_out(mdl_t m);
    logic [1:0] code;
    logic [9:0] a, b, c, d;
    code = (m.ph == 0) ? 2'b00 : (m.ph == 1) ? 2'b10 : (m.ph == 2) ? 2'b11 : 2'b01;
    {a, b, c, d} = {4{10'h3FF}};
    if (m.ph == 1) {a, b, c, d} = {10'(m.p1x), 10'(m.p1y), 10'(m.lx), 10'(m.ly)};
    if (m.ph == 3) {a, b, c, d} = {10'(m.p1x), 10'(m.p1y), 10'(m.p2x), 10'(m.p2y)};
    return {code, (m.ph != 0) || m.done, m.done, a, b, c, d};
  endfunction

  task automatic chk(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // One clock: compare all instances against the model mid-cycle, then advance the model on the edge.
  task automatic cyc();
    @(negedge clk);
    if (cmp_en)
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act[i] !== expect_out(mdl[i])) begin
          failures++;
          $display("FAIL model_dut%0d t=%0t actual=%h required=%h", i, $time, act[i],
                   expect_out(mdl[i]));
        end
      end
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      mdl[i] = step(mdl[i], cf_of[i], tf_of[i], reset, rect_mode, btn_mark, cancel, frame_start,
                    int'(cur_x), int'(cur_y));
    #1;
    cmp_en = 1'b1;
  endtask

  task automatic pulse_mark();
    btn_mark = 1'b1; cyc(); btn_mark = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rect_mode = 1'b0; btn_mark = 1'b0; cancel = 1'b0; frame_start = 1'b0;
    cur_x = 10'd0; cur_y = 10'd0;
    repeat (3) cyc();
    chk("reset_state", ifs[0].state_rect, 2'b00);
    chk("reset_x1", ifs[0].recg_x_pt1, 10'h3FF);
    chk("reset_busy", ifs[0].busy, 0);
    reset = 1'b0; rect_mode = 1'b1; cur_x = 10'd100; cur_y = 10'd50;
    cyc();

    pulse_mark();
    chk("mark1_state", ifs[0].state_rect, 2'b10);
    chk("mark1_x1", ifs[0].recg_x_pt1, 100);
    chk("mark1_y1", ifs[0].recg_y_pt1, 50);
    cur_x = 10'd200; cur_y = 10'd120;
    cyc();
    chk("rubber_x2", ifs[0].recg_x_pt2, 200);
    chk("rubber_y2", ifs[0].recg_y_pt2, 120);
    pulse_mark();
    chk("arm_state", ifs[0].state_rect, 2'b11);
    chk("arm_park", ifs[0].recg_x_pt1, 10'h3FF);
    repeat (2) cyc();
    pulse_fs();
    chk("commit_state", ifs[0].state_rect, 2'b01);
    chk("commit_x1", ifs[0].recg_x_pt1, 100);
    chk("commit_y2", ifs[0].recg_y_pt2, 120);
    cyc();
    pulse_fs();
    chk("end_state", ifs[0].state_rect, 2'b00);
    chk("end_done", ifs[0].commit_done, 1);
    chk("end_busy", ifs[0].busy, 1);
    chk("end_park", ifs[0].recg_x_pt2, 10'h3FF);
    chk("cf2_still", ifs[1].state_rect, 2'b01);
    cyc();
    chk("after_done", ifs[0].commit_done, 0);
    chk("after_busy", ifs[0].busy, 0);

    rect_mode = 1'b0; cancel = 1'b1; btn_mark = 1'b1; cyc(); cancel = 1'b0; btn_mark = 1'b0;
    repeat (2) cyc();
    chk("atomic_state", ifs[1].state_rect, 2'b01);
    chk("atomic_x2", ifs[1].recg_x_pt2, 200);
    pulse_fs();
    chk("atomic_end", ifs[1].state_rect, 2'b00);
    chk("atomic_done", ifs[1].commit_done, 1);
    rect_mode = 1'b1; cyc();

    cur_x = 10'd700; cur_y = 10'd500;
    pulse_mark();
    chk("clamp_x1", ifs[0].recg_x_pt1, 639);
    chk("clamp_y1", ifs[0].recg_y_pt1, 479);
    cancel = 1'b1; btn_mark = 1'b1; cyc(); cancel = 1'b0; btn_mark = 1'b0;
    chk("cancel_prio", ifs[0].state_rect, 2'b00);
    chk("cancel_park", ifs[0].recg_x_pt1, 10'h3FF);

    pulse_mark(); pulse_mark();
    chk("arm2_state", ifs[0].state_rect, 2'b11);
    rect_mode = 1'b0; cyc(); rect_mode = 1'b1;
    chk("arm_mode_drop", ifs[0].state_rect, 2'b00);
    pulse_mark(); pulse_mark();
    cancel = 1'b1; frame_start = 1'b1; cyc(); cancel = 1'b0; frame_start = 1'b0;
    chk("arm_abort_fs", ifs[0].state_rect, 2'b00);

    cur_x = 10'd10; cur_y = 10'd20;
    pulse_mark();
    for (int f = 0; f < 3; f++) begin
      pulse_fs(); cyc(); cyc();
    end
    chk("timeout3", ifs[1].state_rect, 2'b00);
    chk("no_timeout_dflt", ifs[0].state_rect, 2'b10);
    for (int f = 0; f < 300; f++) begin
      pulse_fs(); cyc();
    end
    chk("timeout0_hold", ifs[2].state_rect, 2'b10);
    chk("timeout0_x1", ifs[2].recg_x_pt1, 10);
    chk("timeout255", ifs[0].state_rect, 2'b00);

    cancel = 1'b1; cyc(); cancel = 1'b0;
    cur_x = 10'd5; cur_y = 10'd5;
    pulse_mark(); pulse_mark(); pulse_fs();
    chk("degen_state", ifs[0].state_rect, 2'b01);
    chk("degen_x2", ifs[0].recg_x_pt2, 5);
    pulse_fs();
    chk("degen_done", ifs[0].commit_done, 1);

    pulse_mark(); pulse_mark(); pulse_fs();
    chk("pre_reset", ifs[0].state_rect, 2'b01);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rst_state", ifs[0].state_rect, 2'b00);
    chk("rst_park", ifs[0].recg_y_pt2, 10'h3FF);
    chk("rst_done", ifs[0].commit_done, 0);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
